// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: PC handshake, instruction memory port and decode-side head.
// The unit itself connects through the slave modport; its environment uses master.
interface instr_fetch_unit_if #(
    parameter int unsigned PC_W    = 72,
    parameter int unsigned INSTR_W = 72
);
    logic [PC_W-1:0]    pc_in;
    logic               pc_valid;
    logic               pc_ready;
    logic               flush;
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;
    logic               ir_valid;
    logic [INSTR_W-1:0] ir_data;
    logic [PC_W-1:0]    ir_pc;
    logic               ir_ready;

    modport master (
        output pc_in, pc_valid, flush, mem_gnt, mem_rvalid, mem_rdata, ir_ready,
        input  pc_ready, mem_req, mem_addr, ir_valid, ir_data, ir_pc
    );

    modport slave (
        input  pc_in, pc_valid, flush, mem_gnt, mem_rvalid, mem_rdata, ir_ready,
        output pc_ready, mem_req, mem_addr, ir_valid, ir_data, ir_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit with a prefetch FIFO feeding decode.
// Define FETCH_PERF_CNT_EN to add saturating fetch_count / flush_count outputs.
module instr_fetch_unit #(
    parameter int unsigned PC_W      = 72,
    parameter int unsigned INSTR_W   = 72,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    instr_fetch_unit_if.slave       bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             fetch_count,
    output logic [31:0]             flush_count
`endif
);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] data;
    } entry_t;

    state_t             state, state_nx;
    logic               discard, discard_nx;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_nx, wr_ptr;
    logic [CNT_W-1:0]   count, count_nx;
    entry_t             buf_mem [BUF_DEPTH];
    entry_t             head_nx;
    entry_t             push_entry;
    logic               accept, push, pop;

    // Address acceptance is combinational so a same-cycle flush can veto it.
    assign bus.pc_ready = !reset && (state == IDLE) && !bus.flush && !discard
                          && (count < CNT_W'(BUF_DEPTH));
    assign accept     = bus.pc_valid && bus.pc_ready;
    assign push       = (state == WAIT) && bus.mem_rvalid && !discard && !bus.flush;
    assign pop        = bus.ir_valid && bus.ir_ready && !bus.flush;
    assign push_entry = '{pc: bus.mem_addr, data: bus.mem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            state   <= state_nx;
            discard <= discard_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        discard_nx = discard;
        rd_ptr_nx  = rd_ptr;
        count_nx   = count;
        head_nx    = buf_mem[rd_ptr];

        case (state)
            IDLE:    if (accept)         state_nx = ISSUE;
            ISSUE:   if (bus.mem_gnt)    state_nx = WAIT;
            WAIT:    if (bus.mem_rvalid) state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase

        // A redirect mid-request lets the handshake finish but drops its data.
        if (state_nx == IDLE) begin
            discard_nx = 1'b0;
        end else if (bus.flush) begin
            discard_nx = 1'b1;
        end

        if (bus.flush) begin
            rd_ptr_nx = wr_ptr;
            count_nx  = '0;
        end else begin
            if (pop) begin
                rd_ptr_nx = rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_nx = count + CNT_W'(1);
                2'b01:   count_nx = count - CNT_W'(1);
                default: count_nx = count;
            endcase
        end

        // The new head is either already stored or is the word arriving now.
        if (push && (wr_ptr == rd_ptr_nx)) begin
            head_nx = push_entry;
        end else begin
            head_nx = buf_mem[rd_ptr_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            bus.ir_valid <= 1'b0;
            bus.ir_data  <= '0;
            bus.ir_pc    <= '0;
        end else begin
            bus.mem_req <= (state_nx == ISSUE);
            if (accept) begin
                bus.mem_addr <= bus.pc_in;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr       <= rd_ptr_nx;
            count        <= count_nx;
            bus.ir_valid <= (count_nx != '0);
            if (count_nx != '0) begin
                bus.ir_pc   <= head_nx.pc;
                bus.ir_data <= head_nx.data;
            end
        end
    end

    // Entry storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_mem[wr_ptr] <= push_entry;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push && (fetch_count != 32'hFFFF_FFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (bus.flush && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a queue model.
module tb_instr_fetch_unit;
    localparam int unsigned PC_W    = 72;
    localparam int unsigned INSTR_W = 72;
    localparam int unsigned DEPTH   = 4;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    instr_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .BUF_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .flush_count (flush_count)
`endif
    );

    function automatic logic [INSTR_W-1:0] mword(input logic [PC_W-1:0] a);
        logic [INSTR_W-1:0] k;
        k = 72'hC3_5A5A_1234_5678_9ABC;
        return INSTR_W'(a) ^ k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pc_in      = '0;
        bus.pc_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.ir_ready   = 1'b0;
    endtask

    // Memory-side driver: one complete fetch with immediate grant and response.
    task automatic do_fetch(input logic [PC_W-1:0] pc, output bit ok);
        ok = 1'b0;
        bus.pc_in    = pc;
        bus.pc_valid = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (bus.pc_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            bus.pc_valid = 1'b0;
            return;
        end
        tick();
        bus.pc_valid   = 1'b0;
        bus.mem_gnt    = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mword(pc);
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset        = 1'b1;
        bus.pc_valid = 1'b1;
        bus.pc_in    = 'h48;
        #1;
        checks++;
        if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL reset_pc_ready got %0b exp 0", bus.pc_ready); end
        tick();
        tick();
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b exp 0", bus.mem_req); end
        checks++;
        if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", bus.mem_addr); end
        checks++;
        if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %0b exp 0", bus.ir_valid); end
        checks++;
        if (bus.ir_data !== '0 || bus.ir_pc !== '0) begin
            errors++; $display("FAIL reset_ir_regs got data %0h pc %0h exp 0 0", bus.ir_data, bus.ir_pc);
        end
        reset        = 1'b0;
        bus.pc_valid = 1'b0;
    endtask

    task automatic test_single_fetch();
        logic [INSTR_W-1:0] w;
        w = mword('h48);
        bus.pc_in    = 'h48;
        bus.pc_valid = 1'b1;
        #1;
        checks++;
        if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL single_pc_ready got %0b exp 1", bus.pc_ready); end
        tick();
        bus.pc_valid = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== PC_W'('h48)) begin
            errors++; $display("FAIL single_issue got req %0b addr %0h exp 1 48", bus.mem_req, bus.mem_addr);
        end
        checks++;
        if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL single_busy_ready got %0b exp 0", bus.pc_ready); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.ir_valid !== 1'b0) begin
            errors++; $display("FAIL single_wait got req %0b ir_valid %0b exp 0 0", bus.mem_req, bus.ir_valid);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = w;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++;
        if (bus.ir_valid !== 1'b1 || bus.ir_pc !== PC_W'('h48) || bus.ir_data !== w) begin
            errors++; $display("FAIL single_result got v %0b pc %0h data %0h exp 1 48 %0h",
                               bus.ir_valid, bus.ir_pc, bus.ir_data, w);
        end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        checks++;
        if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL single_pop got %0b exp 0", bus.ir_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [PC_W-1:0] exp_pc;
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_fetch(PC_W'(72 * i), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL bp_fetch_timeout got 0 exp 1 (pc %0d)", 72 * i); end
        end
        checks++;
        if (bus.ir_valid !== 1'b1 || bus.ir_pc !== PC_W'(0)) begin
            errors++; $display("FAIL bp_head got v %0b pc %0h exp 1 0", bus.ir_valid, bus.ir_pc);
        end
        bus.pc_in    = PC_W'(288);
        bus.pc_valid = 1'b1;
        #1;
        checks++;
        if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", bus.pc_ready); end
        tick();
        checks++;
        if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL bp_full_hold got %0b exp 0", bus.pc_ready); end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        #1;
        checks++;
        if (bus.pc_ready !== 1'b1 || bus.ir_pc !== PC_W'(72)) begin
            errors++; $display("FAIL bp_after_pop got ready %0b pc %0h exp 1 48", bus.pc_ready, bus.ir_pc);
        end
        do_fetch(PC_W'(288), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_last_timeout got 0 exp 1"); end
        for (int i = 1; i <= 4; i++) begin
            exp_pc = PC_W'(72 * i);
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir_pc !== exp_pc || bus.ir_data !== mword(exp_pc)) begin
                errors++; $display("FAIL bp_order got v %0b pc %0h data %0h exp 1 %0h %0h",
                                   bus.ir_valid, bus.ir_pc, bus.ir_data, exp_pc, mword(exp_pc));
            end
            bus.ir_ready = 1'b1;
            tick();
            bus.ir_ready = 1'b0;
        end
        checks++;
        if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b exp 0", bus.ir_valid); end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        logic [PC_W-1:0] exp_pc;
        for (int i = 0; i < 3; i++) begin
            do_fetch(PC_W'('h1000 + 8 * i), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL fpp_fill_timeout got 0 exp 1"); end
        end
        bus.pc_in    = PC_W'('h1018);
        bus.pc_valid = 1'b1;
        #1;
        checks++;
        if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL fpp_ready got %0b exp 1", bus.pc_ready); end
        tick();
        bus.pc_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mword(PC_W'('h1018));
        bus.ir_ready   = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.ir_ready   = 1'b0;
        checks++;
        if (bus.ir_valid !== 1'b1 || bus.ir_pc !== PC_W'('h1008)) begin
            errors++; $display("FAIL fpp_head got v %0b pc %0h exp 1 1008", bus.ir_valid, bus.ir_pc);
        end
        do_fetch(PC_W'('h1020), ok);
        bus.pc_in    = PC_W'('h2000);
        bus.pc_valid = 1'b1;
        #1;
        checks++;
        if (!ok || bus.pc_ready !== 1'b0) begin
            errors++; $display("FAIL fpp_full got ok %0b ready %0b exp 1 0", ok, bus.pc_ready);
        end
        bus.pc_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_pc = PC_W'('h1000 + 8 * i);
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir_pc !== exp_pc || bus.ir_data !== mword(exp_pc)) begin
                errors++; $display("FAIL fpp_order got v %0b pc %0h exp 1 %0h", bus.ir_valid, bus.ir_pc, exp_pc);
            end
            bus.ir_ready = 1'b1;
            tick();
            bus.ir_ready = 1'b0;
        end
        checks++;
        if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL fpp_drained got %0b exp 0", bus.ir_valid); end
    endtask

    task automatic test_flush_wait();
        bit ok;
        do_fetch(PC_W'('h500), ok);
        bus.pc_in    = PC_W'('h600);
        bus.pc_valid = 1'b1;
        #1;
        checks++;
        if (!ok || bus.pc_ready !== 1'b1) begin
            errors++; $display("FAIL fw_setup got ok %0b ready %0b exp 1 1", ok, bus.pc_ready);
        end
        tick();
        bus.pc_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.flush   = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.pc_ready !== 1'b0) begin
            errors++; $display("FAIL fw_flushed got v %0b ready %0b exp 0 0", bus.ir_valid, bus.pc_ready);
        end
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mword(PC_W'('h600));
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.pc_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL fw_dropped got v %0b ready %0b req %0b exp 0 1 0",
                               bus.ir_valid, bus.pc_ready, bus.mem_req);
        end
    endtask

    task automatic test_flush_idle();
        bus.pc_in    = PC_W'('h700);
        bus.pc_valid = 1'b1;
        bus.flush    = 1'b1;
        #1;
        checks++;
        if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL fi_ready got %0b exp 0", bus.pc_ready); end
        tick();
        bus.flush    = 1'b0;
        bus.pc_valid = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fi_no_accept got %0b exp 0", bus.mem_req); end
    endtask

    task automatic test_reset_issue();
        bit ok;
        do_fetch(PC_W'('h800), ok);
        bus.pc_in    = PC_W'('h808);
        bus.pc_valid = 1'b1;
        #1;
        tick();
        bus.pc_valid = 1'b0;
        checks++;
        if (!ok || bus.mem_req !== 1'b1) begin
            errors++; $display("FAIL ri_issue got ok %0b req %0b exp 1 1", ok, bus.mem_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.ir_valid !== 1'b0 || bus.mem_addr !== '0) begin
            errors++; $display("FAIL ri_abandon got req %0b v %0b addr %0h exp 0 0 0",
                               bus.mem_req, bus.ir_valid, bus.mem_addr);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mword(PC_W'('h808));
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.pc_ready !== 1'b1) begin
            errors++; $display("FAIL ri_stale got v %0b ready %0b exp 0 1", bus.ir_valid, bus.pc_ready);
        end
    endtask

    // Transaction-level model: phase 0 free, 1 request awaiting grant, 2 awaiting data.
    task automatic test_random();
        ent_t            q[$];
        int              phase;
        bit              disc;
        logic [PC_W-1:0] addr;
        bit              exp_ready, hs, push, pop;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        phase = 0;
        disc  = 1'b0;
        addr  = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++;
            if (bus.mem_req !== (phase == 1) || bus.mem_addr !== addr) begin
                errors++; $display("FAIL rnd_mem cyc %0d got req %0b addr %0h exp %0b %0h",
                                   cyc, bus.mem_req, bus.mem_addr, phase == 1, addr);
            end
            checks++;
            if (bus.ir_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_ir_valid cyc %0d got %0b exp %0b", cyc, bus.ir_valid, q.size() != 0);
            end else if (q.size() != 0) begin
                checks++;
                if (bus.ir_pc !== q[0].pc || bus.ir_data !== q[0].data) begin
                    errors++; $display("FAIL rnd_head cyc %0d got pc %0h data %0h exp %0h %0h",
                                       cyc, bus.ir_pc, bus.ir_data, q[0].pc, q[0].data);
                end
            end

            reset          = ($urandom_range(199) == 0);
            bus.flush      = ($urandom_range(24) == 0);
            bus.pc_valid   = ($urandom_range(3) != 0);
            bus.pc_in      = PC_W'({$urandom, $urandom, $urandom});
            bus.mem_gnt    = ($urandom_range(2) == 0);
            bus.mem_rvalid = ($urandom_range(2) == 0);
            bus.mem_rdata  = INSTR_W'({$urandom, $urandom, $urandom});
            bus.ir_ready   = ($urandom_range(2) == 0);
            #1;
            exp_ready = !reset && phase == 0 && !bus.flush && !disc && q.size() < DEPTH;
            checks++;
            if (bus.pc_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_pc_ready cyc %0d got %0b exp %0b", cyc, bus.pc_ready, exp_ready);
            end

            if (reset) begin
                q.delete();
                phase = 0;
                disc  = 1'b0;
                addr  = '0;
            end else begin
                hs   = bus.pc_valid && exp_ready;
                push = phase == 2 && bus.mem_rvalid && !disc && !bus.flush;
                pop  = bus.ir_ready && q.size() != 0 && !bus.flush;
                if (bus.flush) q.delete();
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{pc: addr, data: bus.mem_rdata});
                if (bus.flush && phase != 0) disc = 1'b1;
                case (phase)
                    0: if (hs) begin phase = 1; addr = bus.pc_in; end
                    1: if (bus.mem_gnt) phase = 2;
                    default: if (bus.mem_rvalid) begin phase = 0; disc = 1'b0; end
                endcase
            end
            tick();
        end
        idle_inputs();
        reset = 1'b0;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_counters();
        bit ok;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_fetch(PC_W'(16 * i), ok);
        end
        bus.ir_ready = 1'b0;
        bus.flush    = 1'b1;
        tick();
        tick();
        bus.flush = 1'b0;
        checks++;
        if (fetch_count !== 32'd5 || flush_count !== 32'd2) begin
            errors++; $display("FAIL counters got fetch %0d flush %0d exp 5 2", fetch_count, flush_count);
        end
    endtask
`endif

    initial begin
        #600000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_full_push_pop();
        test_flush_wait();
        test_flush_idle();
        test_reset_issue();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
